// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// values, ALU control codes, mux selects and the registered control bundle.
package mcu_pkg;

  typedef enum logic [3:0] {
    START,
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTEXE,
    ALUWB,
    IMMEXE,
    BRANCH,
    JUMP
`ifdef ILLEGAL_TRAP_EN
    , ERROR
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_XOR = 6'b100110;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_NOR = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore portion of the control word, registered alongside the state.
  // The *_gate bits qualify the two Mealy outputs (IRWrite, pc_en).
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic [2:0] ula;
    logic       imm_zext;
    logic       illegal;
    logic       fetch_gate;
    logic       branch_gate;
    logic       jump_gate;
  } ctrl_t;

endpackage

// File: rtl/ula_decoder.sv
// Combinational ALU-control decoder: maps OP (and Funct for R-type) to an ALU
// code, flags whether the instruction is supported, and marks logical immediates.
module ula_decoder
  import mcu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] ula_ctrl,
  output logic       legal,
  output logic       logic_imm
);

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    ula_ctrl  = ULA_ADD;
    legal     = 1'b1;
    logic_imm = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   ula_ctrl = ULA_ADD;
          F_SUB:   ula_ctrl = ULA_SUB;
          F_AND:   ula_ctrl = ULA_AND;
          F_OR:    ula_ctrl = ULA_OR;
          F_NOR:   ula_ctrl = ULA_NOR;
          F_SLT:   ula_ctrl = ULA_SLT;
          F_XOR:   ula_ctrl = ULA_XOR;
          default: legal    = 1'b0;
        endcase
      end
      OP_ADDI: ula_ctrl = ULA_ADD;
      OP_ANDI: begin
        ula_ctrl  = ULA_AND;
        logic_imm = 1'b1;
      end
      OP_ORI: begin
        ula_ctrl  = ULA_OR;
        logic_imm = 1'b1;
      end
      OP_XORI: begin
        ula_ctrl  = ULA_XOR;
        logic_imm = 1'b1;
      end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ula_ctrl = ULA_ADD;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with a memory request/ready handshake.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions trap into a sticky ERROR state.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ULACTRL_W  = 3,
  parameter bit LOGIC_ZEXT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           OP,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 pc_en,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 ULASrcA,
  output logic [1:0]           ULASrcB,
  output logic [1:0]           PCSrc,
  output logic [ULACTRL_W-1:0] ULAControl,
  output logic                 imm_zext,
  output logic                 illegal
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       imm_q, imm_d;
  logic       store_q, store_d;
  logic       bne_q, bne_d;

  logic [2:0] dec_ula;
  logic       dec_legal;
  logic       dec_logic_imm;

  ula_decoder u_ula_decoder (
    .op        (OP),
    .funct     (Funct),
    .ula_ctrl  (dec_ula),
    .legal     (dec_legal),
    .logic_imm (dec_logic_imm)
  );

  // Next state, plus the instruction-class flags captured while the IR is known stable.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    store_d = store_q;
    bne_d   = bne_q;
    case (state_q)
      START: state_d = FETCH;
      FETCH: if (mem_ready) state_d = DECODE;
      DECODE: begin
        imm_d   = 1'b0;
        store_d = (OP == OP_SW);
        bne_d   = (OP == OP_BNE);
        if (!dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ERROR;
`else
          state_d = FETCH;
`endif
        end else begin
          case (OP)
            OP_LW, OP_SW:                      state_d = MEMADR;
            OP_RTYPE:                          state_d = RTEXE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
              state_d = IMMEXE;
              imm_d   = 1'b1;
            end
            OP_BEQ, OP_BNE:                    state_d = BRANCH;
            OP_J:                              state_d = JUMP;
            default:                           state_d = FETCH;
          endcase
        end
      end
      MEMADR: state_d = store_q ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      RTEXE:  state_d = ALUWB;
      IMMEXE: state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
      ERROR:  state_d = ERROR;
`endif
      default: state_d = START;
    endcase
  end

  // Control word for the state being entered; registering it keeps the Moore
  // outputs free of decode glitches.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      FETCH: begin
        ctrl_d.mem_req    = 1'b1;
        ctrl_d.src_b      = SRCB_FOUR;
        ctrl_d.ula        = ULA_ADD;
        ctrl_d.pc_src     = PCSRC_ALU;
        ctrl_d.fetch_gate = 1'b1;
      end
      DECODE: begin
        ctrl_d.src_b = SRCB_IMM_SH2;
        ctrl_d.ula   = ULA_ADD;
      end
      MEMADR: begin
        ctrl_d.src_a = 1'b1;
        ctrl_d.src_b = SRCB_IMM;
        ctrl_d.ula   = ULA_ADD;
      end
      MEMRD: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.memto_reg = 1'b1;
      end
      MEMWR: begin
        ctrl_d.mem_req   = 1'b1;
        ctrl_d.iord      = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      RTEXE: begin
        ctrl_d.src_a = 1'b1;
        ctrl_d.src_b = SRCB_REG;
        ctrl_d.ula   = dec_ula;
      end
      ALUWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = ~imm_d;
      end
      IMMEXE: begin
        ctrl_d.src_a    = 1'b1;
        ctrl_d.src_b    = SRCB_IMM;
        ctrl_d.ula      = dec_ula;
        ctrl_d.imm_zext = dec_logic_imm & LOGIC_ZEXT;
      end
      BRANCH: begin
        ctrl_d.src_a       = 1'b1;
        ctrl_d.src_b       = SRCB_REG;
        ctrl_d.ula         = ULA_SUB;
        ctrl_d.pc_src      = PCSRC_ALUOUT;
        ctrl_d.branch_gate = 1'b1;
      end
      JUMP: begin
        ctrl_d.pc_src    = PCSRC_JUMP;
        ctrl_d.jump_gate = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      ERROR: ctrl_d.illegal = 1'b1;
`endif
      default: ctrl_d = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; the async reset also clears the registered
  // control word, so write strobes drop the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      ctrl_q  <= '0;
      imm_q   <= 1'b0;
      store_q <= 1'b0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      store_q <= store_d;
      bne_q   <= bne_d;
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign IorD       = ctrl_q.iord;
  assign MemWrite   = ctrl_q.mem_write;
  assign RegWrite   = ctrl_q.reg_write;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemtoReg   = ctrl_q.memto_reg;
  assign ULASrcA    = ctrl_q.src_a;
  assign ULASrcB    = ctrl_q.src_b;
  assign PCSrc      = ctrl_q.pc_src;
  assign ULAControl = ULACTRL_W'(ctrl_q.ula);
  assign imm_zext   = ctrl_q.imm_zext;
  assign illegal    = ctrl_q.illegal;

  // Only these two respond within the cycle: fetch completion and branch outcome.
  assign IRWrite = ctrl_q.fetch_gate & mem_ready;
  assign pc_en   = (ctrl_q.fetch_gate & mem_ready)
                 | ctrl_q.jump_gate
                 | (ctrl_q.branch_gate & (Zero ^ bne_q));

endmodule
